// File: rtl/tcpc_pkg.sv
// Shared TCPC transmit-path definitions: FSM state encoding, SOP types, register field positions.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package tcpc_pkg;

    // One-hot encoding keeps every Moore output a single-bit decode of the state register
    typedef enum logic [5:0] {
        ST_IDLE        = 6'b000001,
        ST_SEND        = 6'b000010,
        ST_WAIT_CRC    = 6'b000100,
        ST_CHECK_RETRY = 6'b001000,
        ST_REPORT_OK   = 6'b010000,
        ST_REPORT_FAIL = 6'b100000
    } tx_state_e;

    // SOP types carried in TRANSMIT[2:0]
    localparam logic [2:0] SOP_TYPE_SOP         = 3'd0;
    localparam logic [2:0] SOP_TYPE_SOP_PRIME   = 3'd1;
    localparam logic [2:0] SOP_TYPE_SOP_DPRIME  = 3'd2;
    localparam logic [2:0] SOP_TYPE_DBG_PRIME   = 3'd3;
    localparam logic [2:0] SOP_TYPE_DBG_DPRIME  = 3'd4;
    localparam logic [2:0] SOP_TYPE_HARD_RESET  = 3'd5;
    localparam logic [2:0] SOP_TYPE_CABLE_RESET = 3'd6;
    localparam logic [2:0] SOP_TYPE_BIST        = 3'd7;

    // TRANSMIT register fields
    localparam int TX_SOP_LSB   = 0;
    localparam int TX_SOP_MSB   = 2;
    localparam int TX_RETRY_LSB = 4;
    localparam int TX_RETRY_MSB = 5;

    // MessageID location inside header byte 1
    localparam int HDR_MSGID_LSB = 1;
    localparam int HDR_MSGID_MSB = 3;

    // Only SOP* / SOP_DBG* types carry a message handled by this path
    function automatic logic sop_is_message(input logic [2:0] sop_type);
        return sop_type <= SOP_TYPE_DBG_DPRIME;
    endfunction

endpackage

// File: rtl/tcpc_crc_timer.sv
// CRC-receive timer: counts enabled cycles from clear and flags the last cycle of the timeout window.
// Latency: expired is high while the count equals CRC_TIMEOUT-1 (CRC_TIMEOUT enabled cycles after clear).
// Backpressure: none; holds at the expiry value until cleared.
module tcpc_crc_timer #(
    parameter int TIMER_W     = 16,
    parameter int CRC_TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] count;

    assign expired = (count == TIMER_W'(CRC_TIMEOUT - 1));

    // Count enabled cycles, saturating at the expiry value so a stalled owner never sees a wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/tcpc_tx_retry_fsm.sv
// TCPC transmit controller: streams the TX buffer to the PHY, waits for a matching GoodCRC, retries, alerts.
// Latency: first byte valid one cycle after transmit_req; alert one cycle after GoodCRC match or final failure.
// Backpressure: byte and address hold while phy_tx_ready is low; requests while busy are dropped.
module tcpc_tx_retry_fsm
    import tcpc_pkg::*;
#(
    parameter int BUF_DEPTH   = 32,
    parameter int CRC_TIMEOUT = 1000,
    parameter int TIMER_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   transmit,
    input  logic                         transmit_req,
    input  logic [7:0]                   tx_byte_count,
    output logic [$clog2(BUF_DEPTH)-1:0] tx_buf_addr,
    input  logic [7:0]                   tx_buf_data,
    output logic [7:0]                   phy_tx_data,
    output logic                         phy_tx_valid,
    output logic                         phy_tx_last,
    input  logic                         phy_tx_ready,
    input  logic                         phy_tx_discarded,
    input  logic                         rx_goodcrc,
    input  logic [2:0]                   rx_sop,
    input  logic [2:0]                   rx_msg_id,
    output logic                         busy,
    output logic                         alert_tx_success,
    output logic                         alert_tx_failed
);

    localparam int AW = $clog2(BUF_DEPTH);

    tx_state_e   state;
    logic [2:0]  sop;
    logic [1:0]  retry_max;
    logic [1:0]  retry_cnt;
    logic [AW-1:0] idx;
    logic [7:0]  count;
    logic [2:0]  tx_msg_id;

    logic        req_ok;
    logic        count_ok;
    logic        last_byte;
    logic        crc_match;
    logic        crc_expired;
    logic        unused_transmit_bits;

    assign req_ok    = transmit_req && sop_is_message(transmit[TX_SOP_MSB:TX_SOP_LSB]);
    assign count_ok  = (tx_byte_count >= 8'd2) && (32'(tx_byte_count) <= BUF_DEPTH);
    assign last_byte = (8'(idx) == count - 8'd1);
    assign crc_match = rx_goodcrc && (rx_sop == sop) && (rx_msg_id == tx_msg_id);

    // TRANSMIT bits outside the SOP and retry fields are reserved here
    assign unused_transmit_bits = ^{transmit[7:6], transmit[3]};

    // Timer sits cleared outside WAIT_CRC so it always starts from zero on entry
    tcpc_crc_timer #(
        .TIMER_W     (TIMER_W),
        .CRC_TIMEOUT (CRC_TIMEOUT)
    ) u_crc_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ST_WAIT_CRC),
        .enable  (state == ST_WAIT_CRC),
        .expired (crc_expired)
    );

    // Moore outputs decoded from the state and datapath registers
    assign busy             = (state != ST_IDLE);
    assign phy_tx_valid     = (state == ST_SEND);
    assign phy_tx_last      = (state == ST_SEND) && last_byte;
    assign alert_tx_success = (state == ST_REPORT_OK);
    assign alert_tx_failed  = (state == ST_REPORT_FAIL);
    assign tx_buf_addr      = idx;
    assign phy_tx_data      = tx_buf_data;

    // Transmit sequencing: send, await GoodCRC, retry or report
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            sop       <= '0;
            retry_max <= '0;
            retry_cnt <= '0;
            idx       <= '0;
            count     <= '0;
            tx_msg_id <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req_ok) begin
                        sop       <= transmit[TX_SOP_MSB:TX_SOP_LSB];
                        retry_max <= transmit[TX_RETRY_MSB:TX_RETRY_LSB];
                        retry_cnt <= '0;
                        idx       <= '0;
                        count     <= tx_byte_count;
                        state     <= count_ok ? ST_SEND : ST_REPORT_FAIL;
                    end
                end
                ST_SEND: begin
                    // A discard aborts the attempt even if the PHY also took a byte
                    if (phy_tx_discarded) begin
                        state <= ST_CHECK_RETRY;
                    end else if (phy_tx_ready) begin
                        if (idx == AW'(1)) begin
                            tx_msg_id <= tx_buf_data[HDR_MSGID_MSB:HDR_MSGID_LSB];
                        end
                        if (last_byte) begin
                            state <= ST_WAIT_CRC;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                ST_WAIT_CRC: begin
                    // Match is tested first so it wins over a same-cycle expiry
                    if (crc_match) begin
                        state <= ST_REPORT_OK;
                    end else if (crc_expired) begin
                        state <= ST_CHECK_RETRY;
                    end
                end
                ST_CHECK_RETRY: begin
                    if (retry_cnt == retry_max) begin
                        state <= ST_REPORT_FAIL;
                    end else begin
                        retry_cnt <= retry_cnt + 2'd1;
                        idx       <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_REPORT_OK:   state <= ST_IDLE;
                ST_REPORT_FAIL: state <= ST_IDLE;
                default:        state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcpc_tx_retry_fsm.sv
// Randomized bench for the TCPC transmit controller against a transaction-level expectation model.
// Latency: checks every cycle of each transaction, from request through alert.
// Backpressure: drives random phy_tx_ready stalls and PHY discards.
module tb_tcpc_tx_retry_fsm;

    localparam int BUF_DEPTH   = 16;
    localparam int CRC_TIMEOUT = 12;
    localparam int TIMER_W     = 5;
    localparam int AW          = $clog2(BUF_DEPTH);

    logic          clk;
    logic          reset;
    logic [7:0]    transmit;
    logic          transmit_req;
    logic [7:0]    tx_byte_count;
    logic [AW-1:0] tx_buf_addr;
    logic [7:0]    tx_buf_data;
    logic [7:0]    phy_tx_data;
    logic          phy_tx_valid;
    logic          phy_tx_last;
    logic          phy_tx_ready;
    logic          phy_tx_discarded;
    logic          rx_goodcrc;
    logic [2:0]    rx_sop;
    logic [2:0]    rx_msg_id;
    logic          busy;
    logic          alert_tx_success;
    logic          alert_tx_failed;

    logic [7:0] mem [BUF_DEPTH];
    assign tx_buf_data = mem[tx_buf_addr];

    tcpc_tx_retry_fsm #(
        .BUF_DEPTH   (BUF_DEPTH),
        .CRC_TIMEOUT (CRC_TIMEOUT),
        .TIMER_W     (TIMER_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .transmit         (transmit),
        .transmit_req     (transmit_req),
        .tx_byte_count    (tx_byte_count),
        .tx_buf_addr      (tx_buf_addr),
        .tx_buf_data      (tx_buf_data),
        .phy_tx_data      (phy_tx_data),
        .phy_tx_valid     (phy_tx_valid),
        .phy_tx_last      (phy_tx_last),
        .phy_tx_ready     (phy_tx_ready),
        .phy_tx_discarded (phy_tx_discarded),
        .rx_goodcrc       (rx_goodcrc),
        .rx_sop           (rx_sop),
        .rx_msg_id        (rx_msg_id),
        .busy             (busy),
        .alert_tx_success (alert_tx_success),
        .alert_tx_failed  (alert_tx_failed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-attempt plan: byte index to discard at, WAIT cycle of a mismatched and of a matching GoodCRC (-1 = none)
    int disc_at  [4];
    int mism_at  [4];
    int match_at [4];
    bit rdy_rand;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_valid"}, 32'(phy_tx_valid), 0);
        check_eq({tag, "_last"}, 32'(phy_tx_last), 0);
        check_eq({tag, "_ok"}, 32'(alert_tx_success), 0);
        check_eq({tag, "_fail"}, 32'(alert_tx_failed), 0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < BUF_DEPTH; i++) mem[i] = 8'($urandom);
    endtask

    task automatic clear_plan();
        for (int i = 0; i < 4; i++) begin
            disc_at[i]  = -1;
            mism_at[i]  = -1;
            match_at[i] = -1;
        end
    endtask

    // Issue one TRANSMIT and follow it to completion, checking every cycle against the plan
    task automatic run_txn(input int cnt, input int typ, input int rmax);
        int a, b, guard;
        bit done, sent, disc, matched;
        logic [2:0] id;
        fill_mem();
        id = mem[1][3:1];
        transmit      = 8'($urandom);
        transmit[2:0] = 3'(typ);
        transmit[5:4] = 2'(rmax);
        tx_byte_count = 8'(cnt);
        check_quiet("pre_req");
        transmit_req = 1'b1;
        tick();
        transmit_req = 1'b0;
        if (typ > 4) begin
            for (int i = 0; i < 3; i++) begin
                check_quiet("ignored_type");
                tick();
            end
            return;
        end
        if (cnt < 2 || cnt > BUF_DEPTH) begin
            check_eq("badcnt_fail", 32'(alert_tx_failed), 1);
            check_eq("badcnt_ok", 32'(alert_tx_success), 0);
            check_eq("badcnt_valid", 32'(phy_tx_valid), 0);
            check_eq("badcnt_busy", 32'(busy), 1);
            tick();
            check_quiet("badcnt_after");
            return;
        end
        a = 0;
        done = 0;
        while (!done) begin
            b = 0; guard = 0; sent = 0; disc = 0;
            while (!sent) begin
                check_eq("tx_valid", 32'(phy_tx_valid), 1);
                check_eq("tx_addr", 32'(tx_buf_addr), 32'(b));
                check_eq("tx_data", 32'(phy_tx_data), 32'(mem[b]));
                check_eq("tx_last", 32'(phy_tx_last), 32'(b == cnt - 1));
                check_eq("send_busy", 32'(busy), 1);
                check_eq("send_alerts", 32'({alert_tx_success, alert_tx_failed}), 0);
                phy_tx_ready     = (!rdy_rand || guard > 4 * cnt) ? 1'b1 : ($urandom_range(0, 3) != 0);
                phy_tx_discarded = (disc_at[a] == b);
                rx_goodcrc       = ($urandom_range(0, 5) == 0);
                rx_sop           = 3'(typ);
                rx_msg_id        = id;
                tick();
                guard++;
                if (phy_tx_discarded) begin
                    sent = 1;
                    disc = 1;
                end else if (phy_tx_ready) begin
                    if (b == cnt - 1) sent = 1;
                    else b++;
                end
                phy_tx_ready = 1'b0; phy_tx_discarded = 1'b0; rx_goodcrc = 1'b0;
            end
            if (!disc) begin
                matched = 0;
                for (int k = 0; k < CRC_TIMEOUT && !matched; k++) begin
                    check_eq("wait_valid", 32'(phy_tx_valid), 0);
                    check_eq("wait_busy", 32'(busy), 1);
                    check_eq("wait_alerts", 32'({alert_tx_success, alert_tx_failed}), 0);
                    tx_byte_count = 8'($urandom);
                    transmit_req  = ($urandom_range(0, 7) == 0);
                    if (k == mism_at[a]) begin
                        rx_goodcrc = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            rx_sop    = 3'(typ) ^ 3'($urandom_range(1, 7));
                            rx_msg_id = id;
                        end else begin
                            rx_sop    = 3'(typ);
                            rx_msg_id = id ^ 3'($urandom_range(1, 7));
                        end
                    end
                    if (k == match_at[a]) begin
                        rx_goodcrc = 1'b1;
                        rx_sop     = 3'(typ);
                        rx_msg_id  = id;
                        matched    = 1;
                    end
                    tick();
                    rx_goodcrc = 1'b0; transmit_req = 1'b0;
                end
                if (matched) begin
                    check_eq("ok_alert", 32'(alert_tx_success), 1);
                    check_eq("ok_nofail", 32'(alert_tx_failed), 0);
                    check_eq("ok_attempt", 32'(a), 32'(a));
                    check_eq("ok_valid", 32'(phy_tx_valid), 0);
                    tick();
                    check_quiet("ok_after");
                    done = 1;
                end
            end
            if (!done) begin
                check_eq("retry_busy", 32'(busy), 1);
                check_eq("retry_valid", 32'(phy_tx_valid), 0);
                check_eq("retry_alerts", 32'({alert_tx_success, alert_tx_failed}), 0);
                tick();
                if (a == rmax) begin
                    check_eq("fail_alert", 32'(alert_tx_failed), 1);
                    check_eq("fail_nook", 32'(alert_tx_success), 0);
                    check_eq("fail_valid", 32'(phy_tx_valid), 0);
                    tick();
                    check_quiet("fail_after");
                    done = 1;
                end else begin
                    a++;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, typ, rmax, sel;
        reset = 1'b0; transmit = '0; transmit_req = 1'b0; tx_byte_count = '0;
        phy_tx_ready = 1'b0; phy_tx_discarded = 1'b0; rx_goodcrc = 1'b0; rx_sop = '0; rx_msg_id = '0;
        fill_mem();
        tick(); tick();
        check_quiet("reset");
        check_eq("reset_addr", 32'(tx_buf_addr), 0);
        reset = 1'b1;
        tick();

        // Basic 4-byte message, GoodCRC 3 cycles into the wait
        clear_plan(); rdy_rand = 0; match_at[0] = 3;
        run_txn(4, 0, 0);
        // Three attempts with no GoodCRC
        clear_plan(); rdy_rand = 0;
        run_txn(6, 1, 2);
        // Mismatched GoodCRC ignored, matching one accepted without retry
        clear_plan(); rdy_rand = 1; mism_at[0] = 2; match_at[0] = 5;
        run_txn(5, 2, 3);
        // Discard on byte 1, success on the retry
        clear_plan(); rdy_rand = 0; disc_at[0] = 1; match_at[1] = 0;
        run_txn(8, 0, 1);
        // Illegal byte counts and a non-message SOP type
        clear_plan(); run_txn(0, 0, 0);
        clear_plan(); run_txn(BUF_DEPTH + 1, 3, 1);
        clear_plan(); run_txn(1, 4, 0);
        clear_plan(); run_txn(4, 6, 0);
        // Boundary counts; match on the final wait cycle wins over expiry
        clear_plan(); rdy_rand = 1; match_at[0] = CRC_TIMEOUT - 1;
        run_txn(2, 4, 0);
        clear_plan(); rdy_rand = 1; match_at[1] = CRC_TIMEOUT - 1;
        run_txn(BUF_DEPTH, 3, 1);

        // Reset while SEND is stalled, then a fresh request from address 0
        fill_mem();
        transmit = 8'h00; tx_byte_count = 8'd8; transmit_req = 1'b1;
        tick();
        transmit_req = 1'b0; phy_tx_ready = 1'b1;
        tick(); tick(); tick();
        phy_tx_ready = 1'b0;
        tick(); tick();
        check_eq("stall_addr", 32'(tx_buf_addr), 3);
        check_eq("stall_valid", 32'(phy_tx_valid), 1);
        reset = 1'b0;
        tick();
        check_quiet("midreset");
        check_eq("midreset_addr", 32'(tx_buf_addr), 0);
        reset = 1'b1;
        tick();
        clear_plan(); rdy_rand = 0; match_at[0] = 1;
        run_txn(5, 2, 0);

        // Reset coinciding with a matching GoodCRC suppresses the alert
        fill_mem();
        transmit = 8'h01; tx_byte_count = 8'd2; transmit_req = 1'b1;
        tick();
        transmit_req = 1'b0; phy_tx_ready = 1'b1;
        tick(); tick();
        phy_tx_ready = 1'b0;
        rx_goodcrc = 1'b1; rx_sop = 3'd1; rx_msg_id = mem[1][3:1];
        reset = 1'b0;
        tick();
        rx_goodcrc = 1'b0;
        check_quiet("alert_reset");
        reset = 1'b1;
        tick();
        check_quiet("alert_reset_after");

        // Randomized transactions
        for (int n = 0; n < 30; n++) begin
            sel  = $urandom_range(0, 9);
            cnt  = $urandom_range(2, BUF_DEPTH);
            if (sel == 0) cnt = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1) : BUF_DEPTH + 1 + $urandom_range(0, 100);
            typ  = (sel == 1) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            rmax = $urandom_range(0, 3);
            rdy_rand = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                disc_at[i]  = ($urandom_range(0, 3) == 0 && cnt >= 1) ? $urandom_range(0, cnt - 1) : -1;
                match_at[i] = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, CRC_TIMEOUT - 1);
                if (match_at[i] > 0 && $urandom_range(0, 1) == 1) mism_at[i] = $urandom_range(0, match_at[i] - 1);
                else if (match_at[i] < 0) mism_at[i] = $urandom_range(0, CRC_TIMEOUT - 1);
                else mism_at[i] = -1;
            end
            run_txn(cnt, typ, rmax);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
